ex_muldiv: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit that sits beside the combinational EX ALU.
- Executes MULT/MULTU/DIV/DIVU and produces a HI/LO pair plus a one-cycle HILO write strobe.
- The pipeline stalls on busy and discards in-flight work on flush.
- Replaces single-cycle HILO handling with configurable-latency multiply and iterative division.

---
 rtl/ex_muldiv.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit beside the EX ALU: configurable-latency multiply,
// restoring radix-2 divide with sign fix-up, HI/LO result pair and one-cycle write strobe.
module ex_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  hilo_write_en,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  div_by_zero
);
    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (W > MUL_LATENCY) ? W : MUL_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          sgn_reg, sgn_next;
    logic [W-1:0]  opa_reg, opa_next;
    logic [W-1:0]  opb_reg, opb_next;
    logic [W-1:0]  rem_reg, rem_next;
    logic [W-1:0]  quo_reg, quo_next;
    logic [W-1:0]  dvs_reg, dvs_next;
    logic          dbz_reg, dbz_next;
    logic [W-1:0]  hi_reg, hi_next;
    logic [W-1:0]  lo_reg, lo_next;

    // Multiply datapath: both operands widened to 2W so one multiplier serves signed and unsigned.
    logic [2*W-1:0] ext_a, ext_b, product;
    assign ext_a   = {{W{sgn_reg & opa_reg[W-1]}}, opa_reg};
    assign ext_b   = {{W{sgn_reg & opb_reg[W-1]}}, opb_reg};
    assign product = ext_a * ext_b;

    // Divide works on magnitudes; the most negative value maps onto its own unsigned pattern.
    logic [W-1:0] mag_a, mag_b;
    assign mag_a = (sgn_reg && opa_reg[W-1]) ? -opa_reg : opa_reg;
    assign mag_b = (sgn_reg && opb_reg[W-1]) ? -opb_reg : opb_reg;

    logic [W:0]   shifted;
    logic         step_ge;
    logic [W-1:0] step_diff;
    assign shifted   = {rem_reg, quo_reg[W-1]};
    assign step_ge   = shifted >= {1'b0, dvs_reg};
    assign step_diff = shifted[W-1:0] - dvs_reg;

    logic neg_q, neg_r;
    assign neg_q = sgn_reg && (opa_reg[W-1] ^ opb_reg[W-1]);
    assign neg_r = sgn_reg && opa_reg[W-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sgn_next   = sgn_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dvs_next   = dvs_reg;
        dbz_next   = dbz_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sgn_next = ~op[0];
                        opa_next = operand_1;
                        opb_next = operand_2;
                        cnt_next = '0;
                        dbz_next = 1'b0;
                        if (!op[1]) begin
                            state_next = S_MUL;
                        end else if (operand_2 == '0) begin
                            state_next = S_DONE;
                            dbz_next   = 1'b1;
                            hi_next    = operand_1;
                            lo_next    = '1;
                        end else begin
                            state_next = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_reg == MUL_LAST) begin
                        state_next         = S_DONE;
                        {hi_next, lo_next} = product;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                S_DIV: begin
                    // Count 0 loads the magnitudes; counts 1..W each retire one quotient bit.
                    if (cnt_reg == '0) begin
                        rem_next = '0;
                        quo_next = mag_a;
                        dvs_next = mag_b;
                        cnt_next = CNT_ONE;
                    end else begin
                        rem_next = step_ge ? step_diff : shifted[W-1:0];
                        quo_next = {quo_reg[W-2:0], step_ge};
                        if (cnt_reg == DIV_LAST) begin
                            state_next = S_FIX;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                end
                S_FIX: begin
                    hi_next    = neg_r ? -rem_reg : rem_reg;
                    lo_next    = neg_q ? -quo_reg : quo_reg;
                    state_next = S_DONE;
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            sgn_reg   <= 1'b0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            dbz_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sgn_reg   <= sgn_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dvs_reg   <= dvs_next;
            dbz_reg   <= dbz_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // busy covers the acceptance cycle so the pipeline stalls without a bubble.
    assign busy          = rst_n && ((state_reg != S_IDLE) || (start && !flush));
    assign done          = (state_reg == S_DONE);
    assign hilo_write_en = done;
    assign div_by_zero   = done && dbz_reg;
    assign hi_out        = hi_reg;
    assign lo_out        = lo_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv, checked against a plain-arithmetic reference model.
module tb_ex_muldiv;
    localparam int W = 32;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic         busy, done, hilo_write_en, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    ex_muldiv #(.DATA_WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
        .busy(busy), .done(done), .hilo_write_en(hilo_write_en),
        .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // edges = rising edges after the acceptance edge until done is visible.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dbz, output int edges);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        if (o == 2'b00) begin
            p = sa * sb; hi = p[63:32]; lo = p[31:0]; edges = L;
        end else if (o == 2'b01) begin
            p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; edges = L;
        end else if (b == 32'h0) begin
            hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; edges = 0;
        end else if (o == 2'b10) begin
            q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); edges = W + 2;
        end else begin
            lo = a / b; hi = a % b; edges = W + 2;
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dbz, output logic [2:0] hs);
        logic acc_busy, busy_held, single;
        @(negedge clk);
        start = 1'b1; op = o; operand_1 = a; operand_2 = b;
        #1 acc_busy = busy;
        @(negedge clk);
        start = 1'b0; operand_1 = $urandom; operand_2 = $urandom; op = 2'($urandom);
        cyc = 0;
        busy_held = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        hi = hi_out; lo = lo_out; dbz = div_by_zero;
        single = (hilo_write_en === 1'b1);
        @(negedge clk);
        single = single && (done === 1'b0) && (hilo_write_en === 1'b0) && (div_by_zero === 1'b0);
        hs = {acc_busy, busy_held, single};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({done, hilo_write_en, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {done, hilo_write_en, div_by_zero}); end
        n_checks++; if ({hi_out, lo_out} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi_out, lo_out}); end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %b expected 00", {busy, done}); end
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi_out, lo_out);
    endtask

    task automatic test_mult();
        logic [31:0] av[4], bv[4], hi, lo, ehi, elo;
        logic [1:0]  ov[4];
        logic [2:0]  hs;
        logic        dbz, edbz;
        int          cyc, elat;
        ov[0] = 2'b00; av[0] = 32'hFFFF_FFFE; bv[0] = 32'h0000_0003;
        ov[1] = 2'b01; av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF;
        ov[2] = 2'b00; av[2] = 32'h8000_0000; bv[2] = 32'h8000_0000;
        ov[3] = 2'b00; av[3] = 32'h7FFF_FFFF; bv[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            run_op(ov[i], av[i], bv[i], cyc, hi, lo, dbz, hs);
            ref_model(ov[i], av[i], bv[i], ehi, elo, edbz, elat);
            n_checks++; if (cyc !== elat) begin n_fail++; $display("FAIL mult_latency: got %0d expected %0d", cyc, elat); end
            n_checks++; if (hi !== ehi) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi, ehi); end
            n_checks++; if (lo !== elo) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo, elo); end
            n_checks++; if (hs !== 3'b111) begin n_fail++; $display("FAIL mult_handshake: got %b expected 111", hs); end
            last_hi = ehi; last_lo = elo;
            $display("mult op=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d", ov[i], av[i], bv[i], hi, lo, cyc);
        end
    endtask

    task automatic test_div();
        logic [31:0] av[5], bv[5], hi, lo, ehi, elo;
        logic [1:0]  ov[5];
        logic [2:0]  hs;
        logic        dbz, edbz;
        int          cyc, elat;
        ov[0] = 2'b10; av[0] = 32'hFFFF_FFF9; bv[0] = 32'h0000_0002;
        ov[1] = 2'b10; av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
        ov[2] = 2'b11; av[2] = 32'd100;       bv[2] = 32'd7;
        ov[3] = 2'b11; av[3] = 32'h0000_1234; bv[3] = 32'h0;
        ov[4] = 2'b10; av[4] = 32'd7;         bv[4] = 32'hFFFF_FFFE;
        for (int i = 0; i < 5; i++) begin
            run_op(ov[i], av[i], bv[i], cyc, hi, lo, dbz, hs);
            ref_model(ov[i], av[i], bv[i], ehi, elo, edbz, elat);
            n_checks++; if (cyc !== elat) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", cyc, elat); end
            n_checks++; if (hi !== ehi) begin n_fail++; $display("FAIL div_hi: got %h expected %h", hi, ehi); end
            n_checks++; if (lo !== elo) begin n_fail++; $display("FAIL div_lo: got %h expected %h", lo, elo); end
            n_checks++; if (dbz !== edbz) begin n_fail++; $display("FAIL div_by_zero_flag: got %b expected %b", dbz, edbz); end
            n_checks++; if (hs !== 3'b111) begin n_fail++; $display("FAIL div_handshake: got %b expected 111", hs); end
            last_hi = ehi; last_lo = elo;
            $display("div op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b edges=%0d", ov[i], av[i], bv[i], hi, lo, dbz, cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic [1:0]  o;
        logic [2:0]  hs;
        logic        dbz, edbz;
        int          cyc, elat, sel;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) b = 32'($urandom_range(1, 15));
            if (sel == 2) b = 32'hFFFF_FFFF;
            if (sel == 3) a = 32'h8000_0000;
            run_op(o, a, b, cyc, hi, lo, dbz, hs);
            ref_model(o, a, b, ehi, elo, edbz, elat);
            n_checks++; if (cyc !== elat) begin n_fail++; $display("FAIL rand_latency: got %0d expected %0d", cyc, elat); end
            n_checks++; if ({hi, lo} !== {ehi, elo}) begin n_fail++; $display("FAIL rand_hilo: got %h expected %h (op=%0d a=%h b=%h)", {hi, lo}, {ehi, elo}, o, a, b); end
            n_checks++; if (dbz !== edbz) begin n_fail++; $display("FAIL rand_dbz: got %b expected %b", dbz, edbz); end
            n_checks++; if (hs !== 3'b111) begin n_fail++; $display("FAIL rand_handshake: got %b expected 111", hs); end
            last_hi = ehi; last_lo = elo;
            $display("rand op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b edges=%0d", o, a, b, hi, lo, dbz, cyc);
        end
    endtask

    task automatic test_flush();
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic [2:0]  hs;
        logic        dbz, edbz, saw_done;
        int          cyc, elat;
        // Flush ten cycles into a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand_1 = $urandom; operand_2 = $urandom | 32'h1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL flush_div_idle: got %b expected 00", {busy, done}); end
        saw_done = 1'b0;
        a = 32'd1000 + 32'($urandom_range(0, 999)); b = 32'($urandom_range(1, 99));
        run_op(2'b11, a, b, cyc, hi, lo, dbz, hs);
        ref_model(2'b11, a, b, ehi, elo, edbz, elat);
        n_checks++; if (cyc !== elat) begin n_fail++; $display("FAIL flush_restart_latency: got %0d expected %0d", cyc, elat); end
        n_checks++; if ({hi, lo} !== {ehi, elo}) begin n_fail++; $display("FAIL flush_restart_hilo: got %h expected %h", {hi, lo}, {ehi, elo}); end
        last_hi = ehi; last_lo = elo;
        $display("flush div then divu a=%h b=%h -> hi=%h lo=%h", a, b, hi, lo);
        // Flush on the edge a multiply would have completed.
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_1 = $urandom | 32'h1; operand_2 = $urandom | 32'h1;
        @(negedge clk); start = 1'b0;
        repeat (L - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
        n_checks++; if ({hi_out, lo_out} !== {last_hi, last_lo}) begin n_fail++; $display("FAIL flush_hilo_hold: got %h expected %h", {hi_out, lo_out}, {last_hi, last_lo}); end
        $display("flush mul at last edge: done_seen=%b hi=%h lo=%h", saw_done, hi_out, lo_out);
        // Flush and start together: start is dropped.
        start = 1'b1; flush = 1'b1; op = 2'b00; operand_1 = 32'h5; operand_2 = 32'h6;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        @(negedge clk); start = 1'b0; flush = 1'b0;
        repeat (L + 2) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_start_dropped: got %b expected 0", saw_done); end
        $display("flush with start: accepted=%b", saw_done);
        // Flush during the DONE cycle of a divide by zero: result still commits.
        a = $urandom;
        start = 1'b1; op = 2'b11; operand_1 = a; operand_2 = 32'h0;
        @(negedge clk); start = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if ({done, div_by_zero} !== 2'b11) begin n_fail++; $display("FAIL flush_in_done_pulse: got %b expected 11", {done, div_by_zero}); end
        @(negedge clk); flush = 1'b0;
        n_checks++; if ({done, hi_out, lo_out} !== {1'b0, a, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL flush_in_done_hilo: got %h expected %h", {done, hi_out, lo_out}, {1'b0, a, 32'hFFFF_FFFF}); end
        last_hi = a; last_lo = 32'hFFFF_FFFF;
        $display("flush in done: hi=%h lo=%h", hi_out, lo_out);
    endtask

    task automatic test_start_held();
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic        edbz;
        int          cyc, elat, extra;
        a = $urandom; b = 32'($urandom_range(2, 1000)) | 32'h8000_0000;
        ref_model(2'b10, a, b, ehi, elo, edbz, elat);
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand_1 = a; operand_2 = b;
        @(negedge clk);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            operand_1 = $urandom; operand_2 = $urandom; op = 2'($urandom);
            @(negedge clk);
            cyc++;
        end
        hi = hi_out; lo = lo_out;
        start = 1'b0;
        extra = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_checks++; if (cyc !== elat) begin n_fail++; $display("FAIL held_latency: got %0d expected %0d", cyc, elat); end
        n_checks++; if ({hi, lo} !== {ehi, elo}) begin n_fail++; $display("FAIL held_no_relatch: got %h expected %h", {hi, lo}, {ehi, elo}); end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL held_single_done: got %0d expected 0", extra); end
        last_hi = ehi; last_lo = elo;
        $display("start held div a=%h b=%h -> hi=%h lo=%h extra_done=%0d", a, b, hi, lo, extra);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, ehi, elo;
        logic        edbz, bad;
        int          elat, ndone, exp_done, wait_cyc;
        a = $urandom; b = $urandom;
        ref_model(2'b01, a, b, ehi, elo, edbz, elat);
        // Each op costs L edges to done, one DONE cycle and one idle acceptance cycle.
        exp_done = 0;
        for (int k = 0; k < 20; k++) if (k % (L + 2) == L) exp_done++;
        ndone = 0; bad = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_1 = a; operand_2 = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if ({hi_out, lo_out} !== {ehi, elo}) bad = 1'b1;
            end
        end
        start = 1'b0;
        wait_cyc = 0;
        while (busy !== 1'b0 && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
        n_checks++; if (ndone !== exp_done) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected %0d", ndone, exp_done); end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL b2b_hilo: got %b expected 0", bad); end
        n_checks++; if (wait_cyc >= 20) begin n_fail++; $display("FAIL b2b_drain: got %0d expected <20", wait_cyc); end
        last_hi = ehi; last_lo = elo;
        $display("back-to-back multu a=%h b=%h -> dones=%0d", a, b, ndone);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_1 = $urandom | 32'h1; operand_2 = $urandom | 32'h1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_ctrl: got %b expected 00", {busy, done}); end
        n_checks++; if ({hi_out, lo_out} !== 64'h0) begin n_fail++; $display("FAIL reset_mid_hilo: got %h expected 0", {hi_out, lo_out}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (L + 5) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done: got %b expected 0", saw_done); end
        last_hi = '0; last_lo = '0;
        $display("reset mid-mul: hi=%h lo=%h done_seen=%b", hi_out, lo_out, saw_done);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_flush();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
